// File: rtl/nco_mc.sv
`default_nettype none
// nco_mc: multi-channel quadrature NCO built around one shared quarter-wave sine table.
// Optional phase dither is enabled with NCO_DITHER_EN. Rev 1.0
module nco_mc #(
  parameter int NUM_CH         = 2,
  parameter int PHASE_ACC_BITS = 24,
  parameter int LUT_ADDR_BITS  = 8,
  parameter int LUT_DATA_BITS  = 8,
  parameter int CH_BITS        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 sync_clr,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [CH_BITS-1:0]                   cfg_ch,
  input  logic                                 cfg_sel,
  input  logic [PHASE_ACC_BITS-1:0]            cfg_data,
  input  logic                                 cfg_commit,
  output logic                                 cfg_err,
  output logic                                 out_valid,
  output logic [NUM_CH*(LUT_DATA_BITS+1)-1:0]  I,
  output logic [NUM_CH*(LUT_DATA_BITS+1)-1:0]  Q
);

  localparam int PA        = PHASE_ACC_BITS;
  localparam int AW        = LUT_ADDR_BITS;
  localparam int DW        = LUT_DATA_BITS;
  localparam int OW        = LUT_DATA_BITS + 1;
  localparam int TBL       = 1 << LUT_ADDR_BITS;
  localparam int FRAC_BITS = PA - 2 - AW;

  // Table entry from a fixed-point (Q30) Taylor series of sin at the bin centre.
  function automatic logic [LUT_DATA_BITS-1:0] lut_entry(input int idx);
    longint x;
    longint term;
    longint sum;
    x    = (64'sd3373259426 * longint'(2 * idx + 1)) >>> (LUT_ADDR_BITS + 2);
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -(term / longint'((2 * k) * (2 * k + 1)));
      sum  = sum + term;
    end
    sum = (sum * longint'((1 << LUT_DATA_BITS) - 1) + (64'sd1 <<< 29)) >>> 30;
    return sum[LUT_DATA_BITS-1:0];
  endfunction

  logic [DW-1:0] lut [TBL];

  for (genvar t = 0; t < TBL; t++) begin : g_lut
    localparam logic [DW-1:0] C_VAL = lut_entry(t);
    assign lut[t] = C_VAL;
  end

  logic cfg_fire;
  logic cfg_err_q;
  logic v0_q, v1_q, v2_q, v3_q;

  assign cfg_ready = rst & ~cfg_commit;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_err   = cfg_err_q;
  assign out_valid = v3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err_q <= 1'b0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
    end else begin
      if (cfg_fire && (int'(cfg_ch) >= NUM_CH)) cfg_err_q <= 1'b1;
      v0_q <= en;
      v1_q <= v0_q;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  logic [PA-1:0] dither;
`ifdef NCO_DITHER_EN
  localparam int DITH_BITS = (FRAC_BITS > 16) ? 16 : FRAC_BITS;
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else if (en) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  assign dither = {{(PA - DITH_BITS){1'b0}}, lfsr_q[DITH_BITS-1:0]};
`else
  assign dither = '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PA-1:0]        inc_sh_q, off_sh_q, inc_q, off_q, acc_q, ph_q, ph_d;
    logic [1:0]           ph_quad;
    logic [AW-1:0]        ph_f;
    logic [FRAC_BITS-1:0] ph_frac_unused;
    logic [1:0]           quad1_q, quad2_q;
    logic [AW-1:0]        sin_addr_q, cos_addr_q;
    logic [DW-1:0]        sin_mag_q, cos_mag_q;
    logic signed [OW-1:0] sin_pos, cos_pos, i_q, q_q;
    logic                 wr_hit;

    assign wr_hit  = cfg_fire && (int'(cfg_ch) == c);
    assign ph_d    = acc_q + off_q + dither;
    assign {ph_quad, ph_f, ph_frac_unused} = ph_q;
    assign sin_pos = {1'b0, sin_mag_q};
    assign cos_pos = {1'b0, cos_mag_q};

    // ph_q is the issue stage; the odd quadrants walk the table backwards.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        inc_sh_q   <= '0;
        off_sh_q   <= '0;
        inc_q      <= '0;
        off_q      <= '0;
        acc_q      <= '0;
        ph_q       <= '0;
        quad1_q    <= '0;
        quad2_q    <= '0;
        sin_addr_q <= '0;
        cos_addr_q <= '0;
        sin_mag_q  <= '0;
        cos_mag_q  <= '0;
        i_q        <= '0;
        q_q        <= '0;
      end else begin
        if (wr_hit && !cfg_sel) inc_sh_q <= cfg_data;
        if (wr_hit && cfg_sel)  off_sh_q <= cfg_data;
        if (cfg_commit) begin
          inc_q <= inc_sh_q;
          off_q <= off_sh_q;
        end
        if (sync_clr) acc_q <= '0;
        else if (en)  acc_q <= acc_q + inc_q;
        if (en) ph_q <= ph_d;
        if (v0_q) begin
          quad1_q    <= ph_quad;
          sin_addr_q <= ph_quad[0] ? ~ph_f : ph_f;
          cos_addr_q <= ph_quad[0] ? ph_f : ~ph_f;
        end
        if (v1_q) begin
          quad2_q   <= quad1_q;
          sin_mag_q <= lut[sin_addr_q];
          cos_mag_q <= lut[cos_addr_q];
        end
        if (v2_q) begin
          q_q <= quad2_q[1] ? -sin_pos : sin_pos;
          i_q <= (quad2_q[1] ^ quad2_q[0]) ? -cos_pos : cos_pos;
        end
      end
    end

    assign I[c*OW +: OW] = i_q;
    assign Q[c*OW +: OW] = q_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_nco_mc.sv
`default_nettype none
// tb_nco_mc: random + directed stimulus checked against a trig-based reference model.
module tb_nco_mc;

  localparam int NCH  = 2;
  localparam int CHB  = 2;
  localparam int PA   = 24;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int OW   = DW + 1;
  localparam int AMP  = (1 << DW) - 1;
  localparam int LAT  = 3;
  localparam int unsigned MASK = (32'd1 << PA) - 1;
  localparam real PI_R = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en = 1'b0;
  logic                 sync_clr = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [CHB-1:0]       cfg_ch = '0;
  logic                 cfg_sel = 1'b0;
  logic [PA-1:0]        cfg_data = '0;
  logic                 cfg_commit = 1'b0;
  logic                 cfg_err;
  logic                 out_valid;
  logic [NCH*OW-1:0]    I;
  logic [NCH*OW-1:0]    Q;

  nco_mc #(
    .NUM_CH(NCH), .PHASE_ACC_BITS(PA), .LUT_ADDR_BITS(AW),
    .LUT_DATA_BITS(DW), .CH_BITS(CHB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_err(cfg_err), .out_valid(out_valid), .I(I), .Q(Q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int unsigned acc[NCH], inc_a[NCH], off_a[NCH], inc_s[NCH], off_s[NCH];
  bit exp_err, exp_v;
  int exp_i[NCH], exp_q[NCH];
  bit qv[$];
  int qi[$];
  int qq[$];

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_val(input int unsigned ph, input bit is_cos);
    real th, r;
    th = 2.0 * PI_R * (real'(ph >> (PA - 2 - AW)) + 0.5) / real'(4 << AW);
    r  = real'(AMP) * (is_cos ? $cos(th) : $sin(th));
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      acc[c] = 0; inc_a[c] = 0; off_a[c] = 0; inc_s[c] = 0; off_s[c] = 0;
      exp_i[c] = 0; exp_q[c] = 0;
    end
    exp_err = 0; exp_v = 0;
    qv.delete(); qi.delete(); qq.delete();
  endtask

  // One clock edge of the reference, using the inputs currently applied.
  task automatic model_edge();
    bit v;
    int a, b;
    qv.push_back(en);
    for (int c = 0; c < NCH; c++) begin
      int unsigned ph;
      ph = (acc[c] + off_a[c]) & MASK;
      qi.push_back(en ? ref_val(ph, 1'b1) : 0);
      qq.push_back(en ? ref_val(ph, 1'b0) : 0);
    end
    if (qv.size() > LAT) begin
      v = qv.pop_front();
      for (int c = 0; c < NCH; c++) begin
        a = qi.pop_front();
        b = qq.pop_front();
        if (v) begin exp_i[c] = a; exp_q[c] = b; end
      end
      exp_v = v;
    end
    for (int c = 0; c < NCH; c++) begin
      if (sync_clr) acc[c] = 0;
      else if (en)  acc[c] = (acc[c] + inc_a[c]) & MASK;
    end
    if (cfg_commit)
      for (int c = 0; c < NCH; c++) begin inc_a[c] = inc_s[c]; off_a[c] = off_s[c]; end
    if (cfg_valid && !cfg_commit) begin
      if (int'(cfg_ch) >= NCH) exp_err = 1;
      else if (cfg_sel) off_s[cfg_ch] = cfg_data;
      else inc_s[cfg_ch] = cfg_data;
    end
  endtask

  task automatic compare_all();
    check_val("out_valid", int'(out_valid), int'(exp_v));
    check_val("cfg_err", int'(cfg_err), int'(exp_err));
    check_val("cfg_ready", int'(cfg_ready), int'(rst && !cfg_commit));
    for (int c = 0; c < NCH; c++) begin
      check_val($sformatf("I%0d", c), int'($signed(I[c*OW +: OW])), exp_i[c]);
      check_val($sformatf("Q%0d", c), int'($signed(Q[c*OW +: OW])), exp_q[c]);
    end
  endtask

  task automatic tick();
    if (rst) model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic cfg_write(input int ch, input bit sel, input int unsigned data);
    cfg_valid = 1; cfg_ch = CHB'(ch); cfg_sel = sel; cfg_data = PA'(data);
    tick();
    cfg_valid = 0;
  endtask

  task automatic commit();
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    model_reset();
    // reset held low for five cycles
    for (int k = 0; k < 5; k++) tick();
    rst = 1;
    run(2);

    // quarter step on ch0, ch1 idle
    cfg_write(0, 0, 32'd1 << 22);
    commit();
    en = 1;
    run(12);

    // ch1 offset by 90 degrees, committed together with ch0
    cfg_write(1, 0, 32'd1 << 22);
    cfg_write(1, 1, 32'd1 << 22);
    cfg_write(0, 1, 0);
    sync_clr = 1; cfg_commit = 1;
    tick();
    sync_clr = 0; cfg_commit = 0;
    run(10);

    // write colliding with commit is refused; out-of-range channel flags error
    cfg_valid = 1; cfg_ch = 0; cfg_sel = 0; cfg_data = 24'h123456; cfg_commit = 1;
    tick();
    cfg_valid = 0; cfg_commit = 0;
    commit();
    cfg_write(3, 0, 24'h0ABCDE);
    commit();
    run(6);

    // wrap through zero with inc = -1 step, then sync_clr mid-run
    cfg_write(0, 0, MASK);
    cfg_write(0, 1, 32'd5 << 14);
    commit();
    run(8);
    sync_clr = 1;
    tick();
    sync_clr = 0;
    run(6);

    // enable gaps
    for (int k = 0; k < 12; k++) begin
      en = (k % 3) != 1;
      tick();
    end
    en = 0;
    run(6);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      en         = ($urandom_range(0, 3) != 0);
      sync_clr   = ($urandom_range(0, 31) == 0);
      cfg_commit = ($urandom_range(0, 7) == 0);
      cfg_valid  = ($urandom_range(0, 1) == 1);
      cfg_ch     = CHB'($urandom_range(0, NCH - 1));
      cfg_sel    = 1'($urandom_range(0, 1));
      cfg_data   = ($urandom_range(0, 3) == 0) ? PA'($urandom_range(0, 4096)) : PA'($urandom);
      tick();
      if (k == 700) begin
        // asynchronous reset mid-operation, with a write pending
        cfg_valid = 1; cfg_commit = 0;
        #2 rst = 0;
        #1;
        model_reset();
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_I", int'(I), 0);
        check_val("rst_Q", int'(Q), 0);
        check_val("rst_cfg_ready", int'(cfg_ready), 0);
        run(2);
        cfg_valid = 0;
        rst = 1;
      end
    end
    cfg_valid = 0; cfg_commit = 0; sync_clr = 0; en = 0;
    run(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
